// File: rtl/stopwatch_pkg.sv
// Shared constants and quadrature helpers for the stopwatch preset editor.
package stopwatch_pkg;

  localparam int NUM_DIGITS   = 8;
  localparam int BCD_W        = 4;
  localparam int DIGIT_MAX    = 9;
  localparam int MIN_TENS_MAX = 5;

  // Direction codes equal the forward distance (mod 4) along the Gray cycle.
  localparam logic [1:0] DIR_NONE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_ERR  = 2'd2;
  localparam logic [1:0] DIR_DN   = 2'd3;

  // Position of an {A,B} code in the clockwise cycle 00,01,11,10.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic logic [1:0] quad_dir(input logic [1:0] prev_ab,
                                          input logic [1:0] cur_ab);
    return gray_pos(cur_ab) - gray_pos(prev_ab);
  endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: turns A/B transitions into one-cycle detent steps.
module quad_step_decoder
  import stopwatch_pkg::*;
#(
  parameter int DETENT_TRANS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic enc_a_i,
  input  logic enc_b_i,
  output logic step_up_o,
  output logic step_dn_o,
  output logic quad_err_o
);

  localparam int ACC_W = $clog2(DETENT_TRANS) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(DETENT_TRANS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(1);

  logic [1:0]              prev_ab_q, prev_ab_d, cur_ab, dir;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic                    err_q, err_d;

  always_comb begin
    cur_ab    = {enc_a_i, enc_b_i};
    dir       = quad_dir(prev_ab_q, cur_ab);
    prev_ab_d = cur_ab;
    first_d   = 1'b0;
    acc_d     = acc_q;
    err_d     = 1'b0;
    step_up_o = 1'b0;
    step_dn_o = 1'b0;
    // The first sample after reset only seeds prev_ab; it never counts.
    if (!first_q) begin
      err_d = (dir == DIR_ERR);
      if (!en_i) begin
        acc_d = '0;
      end else if (dir == DIR_UP) begin
        if (acc_q == ACC_MAX) begin
          step_up_o = 1'b1;
          acc_d     = '0;
        end else begin
          acc_d = acc_q + ACC_ONE;
        end
      end else if (dir == DIR_DN) begin
        if (acc_q == ACC_MIN) begin
          step_dn_o = 1'b1;
          acc_d     = '0;
        end else begin
          acc_d = acc_q - ACC_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab_q <= 2'b00;
      acc_q     <= '0;
      first_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      prev_ab_q <= prev_ab_d;
      acc_q     <= acc_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  assign quad_err_o = err_q;

endmodule

// File: rtl/preset_digit_editor.sv
// Encoder-driven BCD preset editor: cursor-selected digit steps, clears and change pulse.
module preset_digit_editor
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS   = stopwatch_pkg::NUM_DIGITS,
  parameter int LIMITED_IDX  = 5,
  parameter int DETENT_TRANS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        edit_en,
  input  logic                        enc_a_db,
  input  logic                        enc_b_db,
  input  logic                        enc_btn_rise,
  input  logic                        enc_sw_rise,
  output logic [BCD_W*NUM_DIGITS-1:0] preset_digits,
  output logic [2:0]                  cursor,
  output logic                        preset_changed,
  output logic                        quad_err
);

  localparam logic [2:0] CURSOR_LAST = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] LIMITED_POS = 3'(LIMITED_IDX);

  logic                        step_up, step_dn;
  logic [BCD_W*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [2:0]                  cursor_q, cursor_d;
  logic                        changed_q, changed_d;
  logic [BCD_W-1:0]            cur_digit, new_digit, digit_max;

  quad_step_decoder #(
    .DETENT_TRANS(DETENT_TRANS)
  ) u_decoder (
    .clk       (clk),
    .rst_n     (reset),
    .en_i      (edit_en),
    .enc_a_i   (enc_a_db),
    .enc_b_i   (enc_b_db),
    .step_up_o (step_up),
    .step_dn_o (step_dn),
    .quad_err_o(quad_err)
  );

  // Clear beats a step; every edit targets the cursor position held before this edge.
  always_comb begin
    cur_digit = digits_q[cursor_q*BCD_W +: BCD_W];
    digit_max = (cursor_q == LIMITED_POS) ? BCD_W'(MIN_TENS_MAX) : BCD_W'(DIGIT_MAX);
    new_digit = cur_digit;
    if (edit_en) begin
      if (enc_sw_rise) begin
        new_digit = '0;
      end else if (step_up) begin
        new_digit = (cur_digit >= digit_max) ? '0 : cur_digit + BCD_W'(1);
      end else if (step_dn) begin
        new_digit = (cur_digit == '0) ? digit_max : cur_digit - BCD_W'(1);
      end
    end
    digits_d = digits_q;
    digits_d[cursor_q*BCD_W +: BCD_W] = new_digit;
    changed_d = (new_digit != cur_digit);
    cursor_d  = cursor_q;
    if (edit_en && enc_btn_rise) begin
      cursor_d = (cursor_q == CURSOR_LAST) ? 3'd0 : cursor_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits_q  <= '0;
      cursor_q  <= 3'd0;
      changed_q <= 1'b0;
    end else begin
      digits_q  <= digits_d;
      cursor_q  <= cursor_d;
      changed_q <= changed_d;
    end
  end

  assign preset_digits  = digits_q;
  assign cursor         = cursor_q;
  assign preset_changed = changed_q;

endmodule

// File: tb/tb_preset_digit_editor.sv
// Directed and randomized bench for preset_digit_editor against a behavioural model.
module tb_preset_digit_editor;

  localparam int ND = 8;
  localparam int DT = 4;
  localparam int LIM_IDX = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          edit_en;
  logic          enc_a_db;
  logic          enc_b_db;
  logic          enc_btn_rise;
  logic          enc_sw_rise;
  logic [31:0]   preset_digits;
  logic [2:0]    cursor;
  logic          preset_changed;
  logic          quad_err;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int         m_dig[ND];
  int         m_cur;
  int         m_acc;
  logic [1:0] m_prev;
  bit         m_first;
  int         exp_changed;
  int         exp_err;
  int         pulses;
  logic [1:0] cur_ab;

  // Clockwise cycle position of each {A,B} code, and the code at each position.
  int         pos_of[4] = '{0, 1, 3, 2};
  logic [1:0] gray_at[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  preset_digit_editor #(
    .NUM_DIGITS(ND), .LIMITED_IDX(LIM_IDX), .DETENT_TRANS(DT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .edit_en       (edit_en),
    .enc_a_db      (enc_a_db),
    .enc_b_db      (enc_b_db),
    .enc_btn_rise  (enc_btn_rise),
    .enc_sw_rise   (enc_sw_rise),
    .preset_digits (preset_digits),
    .cursor        (cursor),
    .preset_changed(preset_changed),
    .quad_err      (quad_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_packed();
    logic [31:0] p;
    p = '0;
    for (int i = 0; i < ND; i++) p[4*i +: 4] = 4'(m_dig[i]);
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 0;
    m_cur = 0; m_acc = 0; m_prev = 2'b00; m_first = 1'b1;
    exp_changed = 0; exp_err = 0;
  endtask

  task automatic model_step(input logic [1:0] ab, input logic btn, input logic sw,
                            input logic en);
    int d, lim, old_v, new_v;
    bit up, dn;
    up = 0; dn = 0; exp_err = 0;
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      d = (pos_of[ab] - pos_of[m_prev] + 4) % 4;
      exp_err = (d == 2);
      if (!en) m_acc = 0;
      else if (d == 1) begin
        m_acc++;
        if (m_acc == DT) begin up = 1; m_acc = 0; end
      end else if (d == 3) begin
        m_acc--;
        if (m_acc == -DT) begin dn = 1; m_acc = 0; end
      end
    end
    m_prev = ab;
    lim   = (m_cur == LIM_IDX) ? 5 : 9;
    old_v = m_dig[m_cur];
    new_v = old_v;
    if (en) begin
      if (sw) new_v = 0;
      else if (up) new_v = (old_v + 1) % (lim + 1);
      else if (dn) new_v = (old_v + lim) % (lim + 1);
    end
    exp_changed = (new_v != old_v);
    m_dig[m_cur] = new_v;
    if (en && btn) m_cur = (m_cur + 1) % ND;
  endtask

  task automatic check_all();
    check("digits", preset_digits, model_packed());
    check("cursor", {29'd0, cursor}, 32'(m_cur));
    check("changed", {31'd0, preset_changed}, 32'(exp_changed));
    check("quad_err", {31'd0, quad_err}, 32'(exp_err));
  endtask

  // Drive one cycle of inputs (called at a negedge), model the edge, check after it.
  task automatic tick(input logic [1:0] ab, input logic btn, input logic sw, input logic en);
    cur_ab = ab;
    {enc_a_db, enc_b_db} = ab;
    enc_btn_rise = btn;
    enc_sw_rise  = sw;
    edit_en      = en;
    @(posedge clk);
    model_step(ab, btn, sw, en);
    #1;
    if (preset_changed === 1'b1) pulses++;
    check_all();
    @(negedge clk);
  endtask

  task automatic rotate(input int n, input int dir, input logic en);
    for (int i = 0; i < n; i++)
      tick(gray_at[(pos_of[cur_ab] + dir + 4) % 4], 1'b0, 1'b0, en);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_digits", preset_digits, 32'h0);
    check("rst_cursor", {29'd0, cursor}, 32'h0);
    check("rst_changed", {31'd0, preset_changed}, 32'h0);
    check("rst_quad_err", {31'd0, quad_err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] snap_digits;
  int          snap_cur;

  initial begin
    reset = 1'b0; edit_en = 1'b0; enc_a_db = 1'b0; enc_b_db = 1'b0;
    enc_btn_rise = 1'b0; enc_sw_rise = 1'b0; cur_ab = 2'b00; pulses = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // One clockwise detent from 00.
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    pulses = 0;
    rotate(4, 1, 1'b1);
    check("cw_detent", preset_digits, 32'h0000_0001);
    check("cw_pulses", 32'(pulses), 32'd1);

    // Counter-clockwise wrap 0 -> 9, then reset mid-detent.
    do_reset();
    tick(2'b00, 1'b0, 1'b0, 1'b1);
    rotate(4, -1, 1'b1);
    check("ccw_wrap", preset_digits, 32'h0000_0009);
    rotate(3, -1, 1'b1);
    do_reset();
    tick(cur_ab, 1'b0, 1'b0, 1'b1);
    rotate(1, -1, 1'b1);
    check("acc_discarded", preset_digits, 32'h0);

    // Limited digit at index 5.
    tick(cur_ab, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(cur_ab, 1'b1, 1'b0, 1'b1);
    check("cursor5", {29'd0, cursor}, 32'd5);
    for (int k = 0; k < 6; k++) begin
      rotate(4, 1, 1'b1);
      check("lim_up", {28'd0, preset_digits[23:20]}, 32'((k + 1) % 6));
    end
    rotate(4, -1, 1'b1);
    check("lim_dn_wrap", {28'd0, preset_digits[23:20]}, 32'd5);

    // Illegal transition: both bits change.
    snap_digits = model_packed();
    tick(cur_ab ^ 2'b11, 1'b0, 1'b0, 1'b1);
    check("err_pulse", {31'd0, quad_err}, 32'd1);
    check("err_digits", preset_digits, snap_digits);
    tick(cur_ab, 1'b0, 1'b0, 1'b1);
    check("err_one_cycle", {31'd0, quad_err}, 32'd0);

    // Editing disabled: rotation, button and clear all ignored.
    snap_digits = model_packed();
    snap_cur    = m_cur;
    for (int i = 0; i < 8; i++)
      tick(gray_at[(pos_of[cur_ab] + 1) % 4], i[0], ~i[0], 1'b0);
    check("dis_digits", preset_digits, snap_digits);
    check("dis_cursor", {29'd0, cursor}, 32'(snap_cur));
    pulses = 0;
    rotate(4, 1, 1'b1);
    check("resume_one_step", 32'(pulses), 32'd1);

    // Step completion together with button at cursor 7.
    tick(cur_ab, 1'b1, 1'b0, 1'b1);
    tick(cur_ab, 1'b1, 1'b0, 1'b1);
    check("cursor7", {29'd0, cursor}, 32'd7);
    tick(cur_ab, 1'b0, 1'b0, 1'b0);
    snap_digits = model_packed();
    rotate(3, 1, 1'b1);
    tick(gray_at[(pos_of[cur_ab] + 1) % 4], 1'b1, 1'b0, 1'b1);
    check("step_btn_digit7", {28'd0, preset_digits[31:28]},
          32'((snap_digits[31:28] + 1) % 10));
    check("step_btn_cursor", {29'd0, cursor}, 32'd0);

    // Step completion together with clear.
    rotate(4, 1, 1'b1);
    rotate(3, 1, 1'b1);
    tick(gray_at[(pos_of[cur_ab] + 1) % 4], 1'b0, 1'b1, 1'b1);
    check("step_clear", {28'd0, preset_digits[3:0]}, 32'd0);

    // Randomized phase.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [1:0] nxt;
      if (i == 300) begin
        do_reset();
      end
      r = $urandom_range(0, 9);
      if (r <= 3)      nxt = gray_at[(pos_of[cur_ab] + 1) % 4];
      else if (r <= 6) nxt = gray_at[(pos_of[cur_ab] + 3) % 4];
      else if (r == 8) nxt = cur_ab ^ 2'b11;
      else             nxt = cur_ab;
      tick(nxt, ($urandom_range(0, 7) == 0), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 9) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
